// File: rtl/alu32_seq_shifter.sv
// -----------------------------------------------------------------------------
// alu32_seq_shifter
//
// Iterative 32-bit shift unit (SLL / SRL / SRA / ROL) built around a 32-bit
// bit-reversal block.
//
// The core only ever shifts left, so right shifts use the bit-reversal block:
//   - On the way in, the operand is reversed, which turns a right shift into
//     a left shift.
//   - On the way out, the result is reversed again to restore bit order.
// The shift itself runs as a 5-step logarithmic shift, one stage per clock.
// Stage k shifts by 2^k when Shamt[k] is set.
//
// Latency is fixed. Start is sampled at edge N, the stages run at edges
// N+1..N+5, and Result/Done update at edge N+6.
//
// Ports:
//   Clk    in   1      clock, rising edge
//   Rst    in   1      asynchronous active-high reset
//   Start  in   1      operation request, sampled only in IDLE
//   Op     in   2      00 SLL, 01 SRL, 10 SRA, 11 ROL (sampled with Start)
//   A      in   WIDTH  operand (sampled with Start)
//   Shamt  in   5      shift amount 0..31 (sampled with Start)
//   Busy   out  1      high while an operation is in flight
//   Done   out  1      one-cycle pulse; Result is valid from this cycle
//   Result out  WIDTH  registered result, held until the next Done
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// g_reverse: purely combinational bit-order reversal, q_o[i] = d_i[WIDTH-1-i].
//   d_i  in   WIDTH  input word
//   q_o  out  WIDTH  bit-reversed word
// -----------------------------------------------------------------------------
module g_reverse #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign q_o[i] = d_i[WIDTH-1-i];
   end

endmodule

module alu32_seq_shifter #(
   parameter int WIDTH = 32
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Start,
   input  logic [1:0]       Op,
   input  logic [WIDTH-1:0] A,
   input  logic [4:0]       Shamt,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Result
);

   typedef enum logic [1:0] {
      OP_SLL = 2'b00,
      OP_SRL = 2'b01,
      OP_SRA = 2'b10,
      OP_ROL = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_SHIFT  = 2'b01,
      S_FINISH = 2'b10
   } state_e;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_e           state_q;
   logic [WIDTH-1:0] data_q;    // working shift register
   logic [2:0]       cnt_q;     // current stage index, 0..4
   op_e              op_q;      // latched operation
   logic [4:0]       shamt_q;   // latched shift amount
   logic             fill_q;    // value shifted into vacated LSBs
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] result_q;

   // ---------------------------------------------------------------------------
   // Pre- and post-reversal around the shift core
   // ---------------------------------------------------------------------------
   logic [WIDTH-1:0] a_rev;
   logic [WIDTH-1:0] data_rev;

   g_reverse #(.WIDTH(WIDTH)) u_rev_pre (
      .d_i (A),
      .q_o (a_rev)
   );

   g_reverse #(.WIDTH(WIDTH)) u_rev_post (
      .d_i (data_q),
      .q_o (data_rev)
   );

   op_e  op_in;
   logic right_in;   // incoming request is a right shift
   logic right_q;    // in-flight operation is a right shift

   assign op_in    = op_e'(Op);
   assign right_in = (op_in == OP_SRL) || (op_in == OP_SRA);
   assign right_q  = (op_q  == OP_SRL) || (op_q  == OP_SRA);

   logic [WIDTH-1:0] data_load_d;    // value loaded into data_q on Start
   logic [WIDTH-1:0] result_d;       // value captured into Result at FINISH
   logic             fill_d;

   assign data_load_d = right_in ? a_rev : A;
   assign result_d    = right_q ? data_rev : data_q;
   // A right shift is done as a left shift of the reversed operand. Copies
   // of A[31] therefore land in the LSBs and become sign extension after the
   // final reversal.
   assign fill_d      = (op_in == OP_SRA) ? A[WIDTH-1] : 1'b0;

   // ---------------------------------------------------------------------------
   // Single-stage shifter: shift data_q left by 2^cnt_q when that bit of the
   // amount is set. For ROL the low source is data_q itself, so the bits that
   // leave at the top wrap into the bottom. Otherwise the low source is the
   // fill bit replicated.
   // ---------------------------------------------------------------------------
   logic [WIDTH-1:0] low_src;
   logic [WIDTH-1:0] shifted;
   logic             take;
   logic [WIDTH-1:0] data_d;

   assign low_src = (op_q == OP_ROL) ? data_q : {WIDTH{fill_q}};

   // NOTE: every output of this block gets a default first, so an unlisted
   // cnt_q value can never leave a path unassigned and infer a latch.
   always_comb begin
      shifted = data_q;
      take    = 1'b0;
      case (cnt_q)
         3'd0: begin
            shifted = {data_q[WIDTH-2:0],  low_src[WIDTH-1]};
            take    = shamt_q[0];
         end
         3'd1: begin
            shifted = {data_q[WIDTH-3:0],  low_src[WIDTH-1 -: 2]};
            take    = shamt_q[1];
         end
         3'd2: begin
            shifted = {data_q[WIDTH-5:0],  low_src[WIDTH-1 -: 4]};
            take    = shamt_q[2];
         end
         3'd3: begin
            shifted = {data_q[WIDTH-9:0],  low_src[WIDTH-1 -: 8]};
            take    = shamt_q[3];
         end
         3'd4: begin
            shifted = {data_q[WIDTH-17:0], low_src[WIDTH-1 -: 16]};
            take    = shamt_q[4];
         end
         default: begin
            shifted = data_q;
            take    = 1'b0;
         end
      endcase
      data_d = take ? shifted : data_q;
   end

   // ---------------------------------------------------------------------------
   // Control FSM with registered outputs. Done defaults low each edge and is
   // raised only in FINISH, so it forms a single-cycle pulse.
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values and the update order within the
   // block does not matter.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q  <= S_IDLE;
         data_q   <= '0;
         cnt_q    <= '0;
         op_q     <= OP_SLL;
         shamt_q  <= '0;
         fill_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (Start) begin
                  data_q  <= data_load_d;
                  op_q    <= op_in;
                  shamt_q <= Shamt;
                  fill_q  <= fill_d;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= S_SHIFT;
               end
            end

            S_SHIFT: begin
               data_q <= data_d;
               cnt_q  <= cnt_q + 3'd1;
               if (cnt_q == 3'd4) begin
                  state_q <= S_FINISH;
               end
            end

            S_FINISH: begin
               result_q <= result_d;
               done_q   <= 1'b1;
               busy_q   <= 1'b0;
               state_q  <= S_IDLE;
            end

            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign Busy   = busy_q;
   assign Done   = done_q;
   assign Result = result_q;

endmodule

// File: tb/tb_alu32_seq_shifter.sv
// -----------------------------------------------------------------------------
// tb_alu32_seq_shifter: directed test of alu32_seq_shifter.
// Inputs change on the falling edge and outputs are sampled on the falling
// edge, so both stay clear of the active rising edge.
// -----------------------------------------------------------------------------
module tb_alu32_seq_shifter;

   localparam logic [1:0] SLL = 2'b00;
   localparam logic [1:0] SRL = 2'b01;
   localparam logic [1:0] SRA = 2'b10;
   localparam logic [1:0] ROL = 2'b11;

   logic        Clk;
   logic        Rst;
   logic        Start;
   logic [1:0]  Op;
   logic [31:0] A;
   logic [4:0]  Shamt;
   logic        Busy;
   logic        Done;
   logic [31:0] Result;

   int          n_cmp;
   int          n_err;
   logic [31:0] last_result;

   alu32_seq_shifter #(.WIDTH(32)) dut (
      .Clk    (Clk),
      .Rst    (Rst),
      .Start  (Start),
      .Op     (Op),
      .A      (A),
      .Shamt  (Shamt),
      .Busy   (Busy),
      .Done   (Done),
      .Result (Result)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   task automatic check(input string tag, input logic [31:0] observed,
                        input logic [31:0] expected);
      n_cmp++;
      assert (observed === expected)
      else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Issue one operation and check the whole 6-cycle window cycle by cycle.
   // With disturb set, Start is re-pulsed with different operands while Busy
   // is high; that request must be ignored.
   task automatic run_op(input string tag, input logic [1:0] op,
                         input logic [31:0] a, input logic [4:0] sh,
                         input logic [31:0] expected, input bit disturb);
      @(negedge Clk);
      Start = 1'b1; Op = op; A = a; Shamt = sh;
      @(posedge Clk);                       // edge N
      for (int i = 0; i < 6; i++) begin     // after edges N..N+5
         @(negedge Clk);
         check({tag, " busy"},   {31'd0, Busy}, 32'd1);
         check({tag, " done"},   {31'd0, Done}, 32'd0);
         check({tag, " hold"},   Result, last_result);
         Start = 1'b0;
         if (disturb && i == 2) begin
            Start = 1'b1; Op = SRL; A = 32'h0; Shamt = 5'd7;
         end
      end
      @(negedge Clk);                       // after edge N+6
      Start = 1'b0;
      check({tag, " done@N+6"}, {31'd0, Done}, 32'd1);
      check({tag, " busy@N+6"}, {31'd0, Busy}, 32'd0);
      check({tag, " result"},   Result, expected);
      last_result = expected;
      @(negedge Clk);                       // after edge N+7
      check({tag, " done pulse"}, {31'd0, Done}, 32'd0);
      check({tag, " result held"}, Result, expected);
   endtask

   initial begin
      bit seen_done;
      bit seen_busy;
      n_cmp = 0;
      n_err = 0;
      last_result = 32'h0;
      Rst = 1'b1; Start = 1'b0; Op = SLL; A = 32'h0; Shamt = 5'd0;

      // Reset state
      repeat (2) @(negedge Clk);
      check("reset busy",   {31'd0, Busy}, 32'd0);
      check("reset done",   {31'd0, Done}, 32'd0);
      check("reset result", Result, 32'h0);
      Rst = 1'b0;
      @(negedge Clk);
      check("idle busy", {31'd0, Busy}, 32'd0);

      // Main function and boundaries
      run_op("sll1_31",    SLL, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0);
      run_op("srl80_4",    SRL, 32'h8000_0000, 5'd4,  32'h0800_0000, 1'b0);
      run_op("sra80_4",    SRA, 32'h8000_0000, 5'd4,  32'hF800_0000, 1'b0);
      run_op("sra7f_31",   SRA, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000, 1'b0);
      run_op("rol_1",      ROL, 32'h8000_0001, 5'd1,  32'h0000_0003, 1'b0);
      run_op("rol_0",      ROL, 32'h1234_5678, 5'd0,  32'h1234_5678, 1'b0);
      run_op("rol_31",     ROL, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0);
      run_op("sll_0",      SLL, 32'h1234_5678, 5'd0,  32'h1234_5678, 1'b0);
      run_op("sra_0",      SRA, 32'h8765_4321, 5'd0,  32'h8765_4321, 1'b0);
      run_op("srl_de_12",  SRL, 32'hDEAD_BEEF, 5'd12, 32'h000D_EADB, 1'b0);
      run_op("sra_de_12",  SRA, 32'hDEAD_BEEF, 5'd12, 32'hFFFD_EADB, 1'b0);
      run_op("rol_de_8",   ROL, 32'hDEAD_BEEF, 5'd8,  32'hADBE_EFDE, 1'b0);
      run_op("sll_mix_21", SLL, 32'hA5A5_A5A5, 5'd21, 32'hB4A0_0000, 1'b0);

      // Start re-pulsed during Busy is ignored
      run_op("ignore_start", SLL, 32'h0000_000F, 5'd4, 32'h0000_00F0, 1'b1);
      seen_done = 1'b0;
      repeat (8) begin
         @(negedge Clk);
         if (Done) seen_done = 1'b1;
      end
      check("ignore_start single done", {31'd0, seen_done}, 32'd0);

      // Asynchronous reset in the middle of an operation
      @(negedge Clk);
      Start = 1'b1; Op = SLL; A = 32'hF0F0_F0F0; Shamt = 5'd8;
      @(posedge Clk);                       // edge N
      @(negedge Clk);
      Start = 1'b0;
      repeat (3) @(posedge Clk);            // edge N+3
      #2 Rst = 1'b1;
      #1;
      check("abort busy",   {31'd0, Busy}, 32'd0);
      check("abort done",   {31'd0, Done}, 32'd0);
      check("abort result", Result, 32'h0);
      @(negedge Clk);
      Rst = 1'b0;
      last_result = 32'h0;
      seen_done = 1'b0;
      seen_busy = 1'b0;
      repeat (10) begin
         @(negedge Clk);
         if (Done) seen_done = 1'b1;
         if (Busy) seen_busy = 1'b1;
      end
      check("abort no late done", {31'd0, seen_done}, 32'd0);
      check("abort stays idle",   {31'd0, seen_busy}, 32'd0);
      run_op("after_abort", SRA, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0);

      // Start held high: Done every 7 cycles, Busy low only in Done cycles
      @(negedge Clk);
      Start = 1'b1; Op = SLL; A = 32'h0000_0001; Shamt = 5'd1;
      @(posedge Clk);                       // edge N
      for (int j = 0; j < 21; j++) begin    // after edges N..N+20
         @(negedge Clk);
         if (j == 20) Start = 1'b0;
         check("b2b busy", {31'd0, Busy}, (j % 7 == 6) ? 32'd0 : 32'd1);
         check("b2b done", {31'd0, Done}, (j % 7 == 6) ? 32'd1 : 32'd0);
         if (j >= 6) check("b2b result", Result, 32'h0000_0002);
      end
      @(negedge Clk);
      check("b2b stop busy", {31'd0, Busy}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
